// File: rtl/gsram_seq.sv
// gsram_seq: gSRAM address sequencer with write stream intake and skid-buffered read stream.
// Define GSRAM_SEQ_TRANSPOSE_EN for a column-major read sweep (output is the transpose).
module gsram_seq #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_wr,
  input  logic          start_rd,
  input  logic          in_valid,
  input  logic          in_src,
  output logic          in_ready,
  output logic          g_we,
  output logic [AW-1:0] g_row,
  output logic [AW-1:0] g_col,
  output logic          g_inmuxsel,
  input  logic [DW-1:0] g_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          wr_done,
  output logic          rd_done
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] row, col, row_nx, col_nx;
  logic [DW-1:0] buf_q [2];
  logic [1:0] cnt;
  logic infl, wp, rp, last, acc, issue, pop;
  assign last       = row == AW'(ROWS-1) && col == AW'(COLS-1);
  assign acc        = state == WRITE && in_valid;
  // one credit per buffer slot, counting the word still in the gSRAM read register
  assign issue      = state == READ && (cnt + {1'b0, infl}) < 2'd2;
  assign pop        = out_valid && out_ready;
  assign in_ready   = state == WRITE;
  assign g_we       = acc;
  assign g_inmuxsel = state == WRITE && in_src;
  assign g_row      = row;
  assign g_col      = col;
  assign busy       = state != IDLE;
  assign out_valid  = cnt != 2'd0;
  assign out_data   = buf_q[rp];
  assign rd_done    = state == DRAIN && !infl && cnt == 2'd1 && out_ready;
  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    case (state)
      IDLE: begin
        state_nx = start_wr ? WRITE : start_rd ? READ : IDLE;
        row_nx   = (start_wr || start_rd) ? '0 : row;
        col_nx   = (start_wr || start_rd) ? '0 : col;
      end
      WRITE: if (acc) begin
        if (last) state_nx = IDLE;
        else if (col == AW'(COLS-1)) begin
          col_nx = '0;
          row_nx = row + 1'b1;
        end else col_nx = col + 1'b1;
      end
      READ: if (issue) begin
        if (last) state_nx = DRAIN;
`ifdef GSRAM_SEQ_TRANSPOSE_EN
        else if (row == AW'(ROWS-1)) begin
          row_nx = '0;
          col_nx = col + 1'b1;
        end else row_nx = row + 1'b1;
`else
        else if (col == AW'(COLS-1)) begin
          col_nx = '0;
          row_nx = row + 1'b1;
        end else col_nx = col + 1'b1;
`endif
      end
      DRAIN: state_nx = rd_done ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      infl     <= 1'b0;
      wr_done  <= 1'b0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state   <= state_nx;
      row     <= row_nx;
      col     <= col_nx;
      infl    <= issue;
      wr_done <= acc && last;
      if (infl) begin
        buf_q[wp] <= g_rdata;
        wp        <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, infl} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_gsram_seq.sv
// tb_gsram_seq: scoreboard bench for gsram_seq with a behavioural 10x10x16 gSRAM.
module tb_gsram_seq;
  logic clk = 0, rst_n = 0, start_wr = 0, start_rd = 0, in_valid = 0, in_src = 0, out_ready = 0;
  logic in_ready, g_we, g_inmuxsel, out_valid, busy, wr_done, rd_done;
  logic [3:0] g_row, g_col;
  logic [15:0] g_rdata = 0, out_data, m2 = 0, lut = 0;
  logic [15:0] mem [100];
  int errors = 0, checks = 0;
  int exp_q [$];

  gsram_seq dut (.clk(clk), .rst_n(rst_n), .start_wr(start_wr), .start_rd(start_rd),
    .in_valid(in_valid), .in_src(in_src), .in_ready(in_ready), .g_we(g_we), .g_row(g_row),
    .g_col(g_col), .g_inmuxsel(g_inmuxsel), .g_rdata(g_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .wr_done(wr_done), .rd_done(rd_done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    automatic int idx = int'(g_row) * 10 + int'(g_col);
    if (idx < 100) begin
      if (g_we) mem[idx] <= g_inmuxsel ? lut : m2;
      g_rdata <= mem[idx];
    end
  end

  task automatic test_reset();
    logic [41:0] o;
    #1;
    o = {in_ready, g_we, g_row, g_col, g_inmuxsel, out_valid, out_data, busy, wr_done, rd_done};
    checks++;
    if (o !== 42'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", o); end
    @(negedge clk); rst_n = 1;
    #1 checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_write(input int abort_at, input int stall_at, input bit collide);
    int k = 0, stalls = 0, e;
    logic [41:0] o;
    bit stall;
    @(negedge clk); start_wr = 1; start_rd = collide;
    @(negedge clk); start_wr = 0; start_rd = 0;
    #1 checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL write_entry in_ready got %b want 1", in_ready); end
    while (k < 100) begin
      if (k == abort_at) begin
        in_valid = 1; in_src = 1; rst_n = 0;
        #1;
        o = {in_ready, g_we, g_row, g_col, g_inmuxsel, out_valid, out_data, busy, wr_done, rd_done};
        checks++;
        if (o !== 42'd0) begin errors++; $display("FAIL abort_outputs got %h want 0", o); end
        @(negedge clk); rst_n = 1; in_valid = 0; in_src = 0;
        #1 checks++;
        if (busy !== 1'b0 || wr_done !== 1'b0) begin
          errors++; $display("FAIL abort_idle busy=%b wr_done=%b want 0 0", busy, wr_done);
        end
        return;
      end
      stall = k == stall_at && stalls < 3;
      in_valid = !stall;
      in_src = k[0];
      m2  = k[0] ? 16'hbeef : 16'(k);
      lut = k[0] ? 16'(k) : 16'hdead;
      start_rd = collide && k == 10;
      if (!stall) exp_q.push_back(((k / 10) << 5) | ((k % 10) << 1) | (k & 1));
      #1 checks++;
      if (stall) begin
        stalls++;
        if (g_we !== 1'b0 || g_row !== 4'd5 || g_col !== 4'd5) begin
          errors++; $display("FAIL stall we=%b row=%0d col=%0d want 0 5 5", g_we, g_row, g_col);
        end
      end else if (g_we !== 1'b1) begin
        errors++; $display("FAIL beat%0d g_we got %b want 1", k, g_we);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        if ({g_row, g_col, g_inmuxsel} !== 9'(e)) begin
          errors++; $display("FAIL beat%0d row/col/sel got %0d/%0d/%b want %0d/%0d/%0d",
            k, g_row, g_col, g_inmuxsel, e >> 5, (e >> 1) & 15, e & 1);
        end
      end
      @(negedge clk);
      if (!stall) k++;
    end
    in_valid = 0; start_rd = 0;
    #1 checks++;
    if (wr_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_done_pulse done=%b ready=%b busy=%b want 1 0 0", wr_done, in_ready, busy);
    end
    @(negedge clk); #1 checks++;
    if (wr_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL after_write done=%b busy=%b out_valid=%b want 0 0 0", wr_done, busy, out_valid);
    end
  endtask

  task automatic test_read(input bit backpressure);
    int i = 0, e;
    bit prev_stall = 0, first = 1;
    logic [15:0] prev_data = 0;
    for (int w = 0; w < 100; w++)
`ifdef GSRAM_SEQ_TRANSPOSE_EN
      exp_q.push_back((w % 10) * 10 + w / 10);
`else
      exp_q.push_back(w);
`endif
    @(negedge clk); start_rd = 1;
    @(negedge clk); start_rd = 0;
    while (exp_q.size() > 0 && i < 2000) begin
      out_ready = !backpressure || (i % 4 == 0) || (i % 4 == 3);
      #1;
      if (out_valid && first) begin
        first = 0; checks++;
        if (i != 2) begin errors++; $display("FAIL first_valid cycle got %0d want 2", i); end
      end
      if (out_valid && prev_stall) begin
        checks++;
        if (out_data !== prev_data) begin errors++; $display("FAIL stable got %h want %h", out_data, prev_data); end
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); checks++;
        if (out_data !== 16'(e) || rd_done !== (exp_q.size() == 0)) begin
          errors++; $display("FAIL read word got %0d done=%b want %0d done=%b",
            out_data, rd_done, e, exp_q.size() == 0);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      @(negedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL read_timeout words left %0d want 0", exp_q.size()); end
    exp_q.delete();
    out_ready = 1;
    #1 checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || rd_done !== 1'b0) begin
      errors++; $display("FAIL after_read busy=%b valid=%b done=%b want 0 0 0", busy, out_valid, rd_done);
    end
  endtask

  initial begin
    test_reset();
    test_write(37, -1, 0);
    test_write(-1, 55, 0);
    test_read(0);
    test_read(1);
    test_write(-1, -1, 1);
    test_read(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
